// File: rtl/trade_limiter_pkg.sv
// Shared types and width helpers for the multi-channel trade limiter.
package trade_limiter_pkg;

  // Widest per-channel counter the channel state record can hold.
  localparam int CNT_W_MAX = 16;

  function automatic int ch_idx_w(input int num_ch);
    return (num_ch > 1) ? $clog2(num_ch) : 1;
  endfunction

  // Total-count width: room for every channel saturated plus one spare bit.
  function automatic int total_w(input int num_ch, input int cnt_w);
    return cnt_w + $clog2(num_ch) + 1;
  endfunction

  typedef struct packed {
    logic [CNT_W_MAX-1:0] count;
    logic [CNT_W_MAX-1:0] win_cnt;
    logic                 halt;
    logic                 throttle;
  } ch_state_t;

endpackage

// File: rtl/trade_limiter_if.sv
// Match inputs, control/config and status outputs of the trade limiter.
interface trade_limiter_if
  import trade_limiter_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 8
) ();
  logic [NUM_CH-1:0]                  match_signal;
  logic                               enable_count;
  logic [NUM_CH-1:0]                  clear_ch;
  logic                               clear_all;
  logic                               cfg_we;
  logic [ch_idx_w(NUM_CH)-1:0]        cfg_ch;
  logic [CNT_W-1:0]                   cfg_limit;
  logic [ch_idx_w(NUM_CH)-1:0]        rd_ch;
  logic [CNT_W-1:0]                   rd_count;
  logic [NUM_CH*CNT_W-1:0]            trade_count_vec;
  logic [total_w(NUM_CH, CNT_W)-1:0]  total_count;
  logic [NUM_CH-1:0]                  accept_pulse;
  logic [NUM_CH-1:0]                  halt_vec;
  logic [NUM_CH-1:0]                  throttle_vec;
  logic                               global_halt;

  modport slave (
    input  match_signal, enable_count, clear_ch, clear_all,
           cfg_we, cfg_ch, cfg_limit, rd_ch,
    output rd_count, trade_count_vec, total_count, accept_pulse,
           halt_vec, throttle_vec, global_halt
  );

  modport master (
    output match_signal, enable_count, clear_ch, clear_all,
           cfg_we, cfg_ch, cfg_limit, rd_ch,
    input  rd_count, trade_count_vec, total_count, accept_pulse,
           halt_vec, throttle_vec, global_halt
  );
endinterface

// File: rtl/trade_ch_counter.sv
// One channel: edge detect, programmable lifetime limit, window rate throttle.
module trade_ch_counter
  import trade_limiter_pkg::*;
#(
  parameter int CNT_W         = 8,
  parameter int DEFAULT_LIMIT = 100,
  parameter int RATE_MAX      = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             match_in,
  input  logic             enable_count,
  input  logic             global_halt,
  input  logic             win_term,
  input  logic             clear_ch,
  input  logic             clear_all,
  input  logic             cfg_we,
  input  logic [CNT_W-1:0] cfg_limit,
  output logic             accept,
  output logic             accept_pulse,
  output logic [CNT_W-1:0] count,
  output logic             halt,
  output logic             throttle
);
  localparam logic [CNT_W_MAX-1:0] CNT_SAT  = CNT_W_MAX'({CNT_W{1'b1}});
  localparam logic [CNT_W_MAX-1:0] RATE_LIM = CNT_W_MAX'(RATE_MAX);
  localparam logic [CNT_W_MAX-1:0] ONE      = CNT_W_MAX'(1);

  ch_state_t            st, st_nxt;
  logic                 match_d, edge_det, clr;
  logic [CNT_W-1:0]     limit;
  logic [CNT_W_MAX-1:0] lim_x;

  assign lim_x    = CNT_W_MAX'(limit);
  assign clr      = clear_ch | clear_all;
  assign edge_det = match_in & ~match_d;
  assign accept   = enable_count & edge_det & ~st.halt & ~st.throttle & ~global_halt & ~clr;

  always_comb begin
    st_nxt = st;
    if (clr) begin
      st_nxt = '0;
    end else begin
      if (accept && st.count != CNT_SAT && (limit == '0 || st.count < lim_x))
        st_nxt.count = st.count + ONE;
      // Evaluated every cycle so a lowered limit halts on the following edge.
      if (limit != '0 && st_nxt.count >= lim_x)
        st_nxt.halt = 1'b1;
      if (win_term) begin
        st_nxt.win_cnt  = '0;
        st_nxt.throttle = 1'b0;
      end else if (accept) begin
        st_nxt.win_cnt = st.win_cnt + ONE;
        if (st_nxt.win_cnt >= RATE_LIM) st_nxt.throttle = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      st           <= '0;
      match_d      <= 1'b0;
      accept_pulse <= 1'b0;
      limit        <= CNT_W'(DEFAULT_LIMIT);
    end else begin
      st           <= st_nxt;
      match_d      <= match_in;
      accept_pulse <= accept;
      if (cfg_we) limit <= cfg_limit;
    end
  end

  assign count    = st.count[CNT_W-1:0];
  assign halt     = st.halt;
  assign throttle = st.throttle;

endmodule

// File: rtl/trade_limiter.sv
// Multi-channel trade counter / rate limiter with a saturating global total.
module trade_limiter
  import trade_limiter_pkg::*;
#(
  parameter int NUM_CH        = 4,
  parameter int CNT_W         = 8,
  parameter int DEFAULT_LIMIT = 100,
  parameter int WINDOW_CYCLES = 1024,
  parameter int RATE_MAX      = 8,
  parameter int GLOBAL_MAX    = 255
) (
  input logic             clk,
  input logic             reset,
  trade_limiter_if.slave  bus
);
  localparam int IDX_W = ch_idx_w(NUM_CH);
  localparam int TOT_W = total_w(NUM_CH, CNT_W);
  localparam int TMR_W = $clog2(WINDOW_CYCLES);

  logic [TMR_W-1:0]              win_timer;
  logic                          win_term, global_halt;
  logic [NUM_CH-1:0]             accept, cfg_sel, pulse, halt, throttle;
  logic [NUM_CH-1:0][CNT_W-1:0]  counts;
  logic [TOT_W:0]                tot_sum;
  logic [TOT_W-1:0]              total, total_nxt;
  logic [CNT_W-1:0]              rd_mux;

  assign win_term = (win_timer == TMR_W'(WINDOW_CYCLES - 1));

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    // Channel indices with no instance never match, so such writes are dropped.
    assign cfg_sel[g] = bus.cfg_we & (bus.cfg_ch == IDX_W'(g));
    trade_ch_counter #(
      .CNT_W(CNT_W), .DEFAULT_LIMIT(DEFAULT_LIMIT), .RATE_MAX(RATE_MAX)
    ) u_ch (
      .clk(clk), .reset(reset),
      .match_in(bus.match_signal[g]), .enable_count(bus.enable_count),
      .global_halt(global_halt), .win_term(win_term),
      .clear_ch(bus.clear_ch[g]), .clear_all(bus.clear_all),
      .cfg_we(cfg_sel[g]), .cfg_limit(bus.cfg_limit),
      .accept(accept[g]), .accept_pulse(pulse[g]), .count(counts[g]),
      .halt(halt[g]), .throttle(throttle[g])
    );
  end

  always_comb begin
    tot_sum = {1'b0, total};
    for (int i = 0; i < NUM_CH; i++) tot_sum = tot_sum + (TOT_W+1)'(accept[i]);
    total_nxt = tot_sum[TOT_W] ? '1 : tot_sum[TOT_W-1:0];
  end

  always_comb begin
    rd_mux = '0;
    for (int i = 0; i < NUM_CH; i++)
      if (bus.rd_ch == IDX_W'(i)) rd_mux = counts[i];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      win_timer     <= '0;
      total         <= '0;
      global_halt   <= 1'b0;
      bus.rd_count  <= '0;
    end else begin
      bus.rd_count <= rd_mux;
      if (bus.clear_all) begin
        win_timer   <= '0;
        total       <= '0;
        global_halt <= 1'b0;
      end else begin
        win_timer   <= win_term ? '0 : win_timer + TMR_W'(1);
        total       <= total_nxt;
        global_halt <= global_halt | (32'(total_nxt) >= 32'(GLOBAL_MAX));
      end
    end
  end

  assign bus.trade_count_vec = counts;
  assign bus.total_count     = total;
  assign bus.accept_pulse    = pulse;
  assign bus.halt_vec        = halt;
  assign bus.throttle_vec    = throttle;
  assign bus.global_halt     = global_halt;

endmodule

// File: tb/tb_trade_limiter.sv
// Bench for trade_limiter: scenario sequences plus random stimulus vs a window-log model.
module tb_trade_limiter;
  localparam int NUM_CH = 4, CNT_W = 8, DEF_LIM = 5, WIN = 16, RATE = 3, GMAX = 12;
  localparam int TOT_MAX = (1 << (CNT_W + 2 + 1)) - 1;

  logic clk = 1'b0;
  logic reset = 1'b1;
  trade_limiter_if #(.NUM_CH(NUM_CH), .CNT_W(CNT_W)) bus();
  trade_limiter #(
    .NUM_CH(NUM_CH), .CNT_W(CNT_W), .DEFAULT_LIMIT(DEF_LIM),
    .WINDOW_CYCLES(WIN), .RATE_MAX(RATE), .GLOBAL_MAX(GMAX)
  ) dut (.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] match;
    logic       en;
    logic [3:0] clr_ch;
    logic       clr_all;
    logic       cfg_we;
    logic [1:0] cfg_ch;
    logic [7:0] cfg_limit;
    logic [1:0] rd_ch;
  } stim_t;

  typedef struct {
    logic [3:0] match;
    logic       exp_pulse0;
    int         exp_cnt0;
    int         exp_total;
  } vec_t;

  stim_t stim;
  vec_t  tbl[11];
  int    checks = 0, errors = 0;

  // Reference: counts/limits as ints; the rate window is a log of the window
  // index of each accept, throttle = enough logged accepts in the current window.
  int m_cnt[4], m_lim[4], m_md[4], m_q[4][$];
  bit m_halt[4], m_pulse[4], m_gh;
  int m_total, m_cyc, m_rd;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic int thr_of(int ch, int cyc);
    int n = 0;
    foreach (m_q[ch][k]) if (m_q[ch][k] == cyc / WIN) n++;
    return (n >= RATE) ? 1 : 0;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      m_cnt[i] = 0; m_lim[i] = DEF_LIM; m_md[i] = 0; m_q[i].delete();
      m_halt[i] = 0; m_pulse[i] = 0;
    end
    m_gh = 0; m_total = 0; m_cyc = 0; m_rd = 0;
  endtask

  task automatic model_step();
    bit acc[4];
    int nacc = 0;
    for (int i = 0; i < 4; i++) begin
      acc[i] = stim.en && stim.match[i] && !m_md[i] && !m_halt[i] && thr_of(i, m_cyc) == 0
               && !m_gh && !stim.clr_ch[i] && !stim.clr_all;
      nacc += int'(acc[i]);
    end
    m_rd = m_cnt[stim.rd_ch];
    for (int i = 0; i < 4; i++) begin
      m_pulse[i] = acc[i];
      m_md[i] = int'(stim.match[i]);
      if (stim.clr_ch[i] || stim.clr_all) begin
        m_cnt[i] = 0; m_halt[i] = 0; m_q[i].delete();
      end else begin
        if (acc[i]) begin
          m_q[i].push_back(m_cyc / WIN);
          if (m_cnt[i] < 255 && (m_lim[i] == 0 || m_cnt[i] < m_lim[i])) m_cnt[i]++;
        end
        if (m_lim[i] != 0 && m_cnt[i] >= m_lim[i]) m_halt[i] = 1;
      end
    end
    if (stim.clr_all) begin
      m_total = 0; m_gh = 0; m_cyc = 0;
    end else begin
      m_total = (m_total + nacc > TOT_MAX) ? TOT_MAX : m_total + nacc;
      if (m_total >= GMAX) m_gh = 1;
      m_cyc++;
    end
    if (stim.cfg_we) m_lim[stim.cfg_ch] = int'(stim.cfg_limit);
  endtask

  task automatic compare_model();
    logic [3:0] ep, eh, et;
    for (int i = 0; i < 4; i++) begin
      ep[i] = m_pulse[i]; eh[i] = m_halt[i]; et[i] = (thr_of(i, m_cyc) != 0);
      chk("model_count", 32'(bus.trade_count_vec[i*CNT_W +: CNT_W]), 32'(m_cnt[i]));
    end
    chk("model_accept_pulse", 32'(bus.accept_pulse), 32'(ep));
    chk("model_halt_vec", 32'(bus.halt_vec), 32'(eh));
    chk("model_throttle_vec", 32'(bus.throttle_vec), 32'(et));
    chk("model_global_halt", 32'(bus.global_halt), 32'(m_gh));
    chk("model_total", 32'(bus.total_count), 32'(m_total));
    chk("model_rd_count", 32'(bus.rd_count), 32'(m_rd));
  endtask

  task automatic step();
    bus.match_signal = stim.match;   bus.enable_count = stim.en;
    bus.clear_ch     = stim.clr_ch;  bus.clear_all    = stim.clr_all;
    bus.cfg_we       = stim.cfg_we;  bus.cfg_ch       = stim.cfg_ch;
    bus.cfg_limit    = stim.cfg_limit; bus.rd_ch      = stim.rd_ch;
    @(posedge clk);
    model_step();
    #1;
    compare_model();
    stim.clr_ch = '0; stim.clr_all = 1'b0; stim.cfg_we = 1'b0;
  endtask

  task automatic hi(input logic [3:0] m);
    stim.match = m; step();
  endtask

  task automatic idle(input int n);
    stim.match = '0;
    repeat (n) step();
  endtask

  task automatic clear_all_step();
    stim.match = '0; stim.clr_all = 1'b1; step();
  endtask

  task automatic write_limit(input logic [1:0] ch, input logic [7:0] lim);
    stim.cfg_we = 1'b1; stim.cfg_ch = ch; stim.cfg_limit = lim; step();
  endtask

  function automatic logic [7:0] cnt_of(int ch);
    return bus.trade_count_vec[ch*CNT_W +: CNT_W];
  endfunction

  task automatic check_all_zero(string tag);
    chk({tag, "_counts"}, 32'(bus.trade_count_vec), 0);
    chk({tag, "_total"}, 32'(bus.total_count), 0);
    chk({tag, "_pulse"}, 32'(bus.accept_pulse), 0);
    chk({tag, "_halt"}, 32'(bus.halt_vec), 0);
    chk({tag, "_throttle"}, 32'(bus.throttle_vec), 0);
    chk({tag, "_ghalt"}, 32'(bus.global_halt), 0);
    chk({tag, "_rd"}, 32'(bus.rd_count), 0);
  endtask

  initial begin
    stim = '{match: '0, en: 1'b1, clr_ch: '0, clr_all: 1'b0, cfg_we: 1'b0,
             cfg_ch: '0, cfg_limit: '0, rd_ch: '0};
    bus.match_signal = '0; bus.enable_count = 1'b1; bus.clear_ch = '0; bus.clear_all = 1'b0;
    bus.cfg_we = 1'b0; bus.cfg_ch = '0; bus.cfg_limit = '0; bus.rd_ch = '0;
    model_reset();
    #12;
    check_all_zero("reset");
    reset = 1'b0;

    // Held-high match on ch0: exactly one accept.
    tbl[0] = '{4'b0001, 1'b1, 1, 1};
    for (int k = 1; k < 10; k++) tbl[k] = '{4'b0001, 1'b0, 1, 1};
    tbl[10] = '{4'b0000, 1'b0, 1, 1};
    for (int k = 0; k < 11; k++) begin
      stim.match = tbl[k].match;
      step();
      chk("held_pulse0", 32'(bus.accept_pulse[0]), 32'(tbl[k].exp_pulse0));
      chk("held_count0", 32'(cnt_of(0)), 32'(tbl[k].exp_cnt0));
      chk("held_total", 32'(bus.total_count), 32'(tbl[k].exp_total));
    end

    // Ch1 reaches its lifetime limit over several windows.
    clear_all_step();
    stim.rd_ch = 2'd1;
    for (int k = 0; k < 5; k++) begin
      hi(4'b0010);
      chk("limit_pulse1", 32'(bus.accept_pulse[1]), 1);
      chk("limit_halt1", 32'(bus.halt_vec[1]), (k == 4) ? 1 : 0);
      idle(7);
    end
    chk("limit_count1", 32'(cnt_of(1)), 5);
    hi(4'b0010);
    chk("limit_drop_pulse1", 32'(bus.accept_pulse[1]), 0);
    chk("limit_hold_count1", 32'(cnt_of(1)), 5);
    idle(1);

    // Ch2 burst throttled within one window, released at wrap.
    clear_all_step();
    stim.rd_ch = 2'd2;
    for (int k = 0; k < 4; k++) begin
      hi(4'b0100);
      if (k == 2) begin
        chk("thr_set2", 32'(bus.throttle_vec[2]), 1);
        chk("thr_count2", 32'(cnt_of(2)), 3);
      end
      if (k == 3) chk("thr_drop_pulse2", 32'(bus.accept_pulse[2]), 0);
      idle(1);
    end
    idle(10);
    chk("thr_wrap_clear2", 32'(bus.throttle_vec[2]), 0);
    hi(4'b0100);
    chk("thr_after_pulse2", 32'(bus.accept_pulse[2]), 1);
    chk("thr_after_count2", 32'(cnt_of(2)), 4);
    idle(1);

    // Lowering ch3 limit below its count halts next edge; clear wins over edge.
    clear_all_step();
    stim.rd_ch = 2'd3;
    for (int k = 0; k < 3; k++) begin hi(4'b1000); idle(1); end
    chk("cfg_count3", 32'(cnt_of(3)), 3);
    write_limit(2'd3, 8'd2);
    chk("cfg_halt3_write_cycle", 32'(bus.halt_vec[3]), 0);
    idle(1);
    chk("cfg_halt3_next", 32'(bus.halt_vec[3]), 1);
    stim.clr_ch = 4'b1000;
    hi(4'b1000);
    chk("clr_count3", 32'(cnt_of(3)), 0);
    chk("clr_halt3", 32'(bus.halt_vec[3]), 0);
    chk("clr_pulse3", 32'(bus.accept_pulse[3]), 0);
    idle(1);
    write_limit(2'd3, 8'd5);

    // All channels together until the global halt; clear_all keeps limits.
    clear_all_step();
    for (int r = 0; r < 4; r++) begin
      hi(4'b1111);
      chk("glob_total", 32'(bus.total_count), (r < 3) ? 32'(4 * (r + 1)) : 32'd12);
      chk("glob_halt", 32'(bus.global_halt), (r >= 2) ? 1 : 0);
      if (r == 3) chk("glob_drop_pulse", 32'(bus.accept_pulse), 0);
      idle(7);
    end
    write_limit(2'd2, 8'd1);
    clear_all_step();
    chk("clrall_total", 32'(bus.total_count), 0);
    chk("clrall_ghalt", 32'(bus.global_halt), 0);
    hi(4'b0100);
    chk("clrall_limit_kept2", 32'(bus.halt_vec[2]), 1);
    idle(1);
    write_limit(2'd2, 8'd5);

    // Asynchronous reset with match held high.
    clear_all_step();
    stim.rd_ch = 2'd0;
    hi(4'b0001); idle(1); hi(4'b0001);
    chk("rst_pre_count0", 32'(cnt_of(0)), 2);
    #2 reset = 1'b1;
    #1;
    check_all_zero("async_reset");
    model_reset();
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    step();
    chk("rst_rearm_pulse0", 32'(bus.accept_pulse[0]), 1);
    chk("rst_rearm_count0", 32'(cnt_of(0)), 1);
    chk("rst_rearm_total", 32'(bus.total_count), 1);

    // Random traffic against the reference.
    for (int n = 0; n < 800; n++) begin
      stim.match     = 4'($urandom);
      stim.en        = ($urandom_range(7) != 0);
      stim.clr_ch    = ($urandom_range(15) == 0) ? 4'(1 << $urandom_range(3)) : 4'b0;
      stim.clr_all   = ($urandom_range(40) == 0);
      stim.cfg_we    = ($urandom_range(19) == 0);
      stim.cfg_ch    = 2'($urandom);
      stim.cfg_limit = 8'($urandom_range(9));
      stim.rd_ch     = 2'($urandom);
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/trade_limiter.md
# trade_limiter

Multi-channel trade counter and rate limiter for the matching engine, the parametrised successor of the single-channel trade counter.
- Per channel: edge-detects match pulses, counts accepted trades against a run-time programmable lifetime limit, and throttles bursts over a fixed time window.
- Global: maintains a total across all channels with its own halt threshold.
- Sits between the per-symbol match outputs and the order-entry gating logic; halt and throttle vectors feed back to block new orders.

## Interface
- NUM_CH, 4, number of independent trade channels (1..16)
- CNT_W, 8, width of per-channel counters and limits
- DEFAULT_LIMIT, 100, per-channel limit after reset; 0 = unlimited
- WINDOW_CYCLES, 1024, length of rate window in clk cycles (≥2)
- RATE_MAX, 8, accepted trades per channel per window before throttle (≥1)
- GLOBAL_MAX, 255, total accepted trades before global halt
- clk  in  1  clock
- reset  in  1  reset, asynchronous, active-high
- match_signal  in  NUM_CH  per-channel match level from matcher
- enable_count  in  1  global count enable
- clear_ch  in  NUM_CH  per-channel clear pulse
- clear_all  in  1  clear all state except limit registers
- cfg_we  in  1  limit write strobe
- cfg_ch  in  $clog2(NUM_CH)  channel for limit write
- cfg_limit  in  CNT_W  new limit value
- rd_ch  in  $clog2(NUM_CH)  readback channel select
- rd_count  out  CNT_W  count of rd_ch, registered
- trade_count_vec  out  NUM_CH*CNT_W  all channel counts, channel 0 in LSBs
- total_count  out  CNT_W+$clog2(NUM_CH)+1  sum of all accepted trades, saturating
- accept_pulse  out  NUM_CH  one-cycle registered pulse per accepted trade
- halt_vec  out  NUM_CH  per-channel lifetime-limit halt
- throttle_vec  out  NUM_CH  per-channel window throttle
- global_halt  out  1  total reached GLOBAL_MAX

## Operation
- Reset:
  - All outputs, counts, edge registers, window timer, throttle and halts = 0.
  - Limits = DEFAULT_LIMIT.
- Edge detect: edge[i] = match_signal[i] & ~match_d[i]. match_d is registered every cycle regardless of enable or halt.
- accept[i] = enable_count & edge[i] & ~halt_vec[i] & ~throttle_vec[i] & ~global_halt & ~clear_ch[i] & ~clear_all.
- Accepted edge:
  - count[i] += 1; count never exceeds limit[i] (limit≠0) and saturates at 2^CNT_W−1.
  - win_cnt[i] += 1.
  - total_count += 1 (sum of simultaneous accepts, saturating at all ones).
- halt_vec[i] is sticky:
  - Set at the edge where limit[i]≠0 and the next count ≥ limit[i].
  - Also set after a limit write at or below the current count, at the edge following the write.
  - Raising the limit does not clear halt; only clear_ch[i], clear_all or reset do.
- Window:
  - win_timer counts 0..WINDOW_CYCLES−1 and wraps.
  - throttle_vec[i] sets at the edge where win_cnt[i] reaches RATE_MAX.
  - In the terminal cycle (win_timer = WINDOW_CYCLES−1), all win_cnt and throttle_vec clear at that edge. An accept in that cycle still updates count/total, but its window contribution is discarded.
- Global: global_halt sets at the edge where the next total_count ≥ GLOBAL_MAX; sticky until clear_all or reset.
- clear_ch[i]:
  - Zeroes count[i], win_cnt[i], halt_vec[i] and throttle_vec[i].
  - Wins over a simultaneous accept on that channel; the edge is dropped, not deferred.
  - Does not alter total_count.
- clear_all:
  - Clears every clear_ch target plus total_count, global_halt and win_timer.
  - Limits are retained.
- Config: cfg_we writes cfg_limit into limit[cfg_ch] at the edge; it takes effect for accepts from the next cycle. An out-of-range cfg_ch is ignored.

## Timing
- Match rise sampled in cycle T:
  - accept_pulse, count, win_cnt and total are visible in T+1.
  - halt/throttle/global_halt are visible in T+1 when set by that accept.
- A match level held high yields exactly one accept. A re-trigger requires a low cycle.
- Accepts in T+1 already see a halt set at the end of T; no overshoot.
- rd_count = count[rd_ch] as of the start of the cycle, registered, so it appears 1 cycle after rd_ch is applied.
- Reset mid-window or mid-pulse: immediate clear. match_d = 0, so a level still high after deassertion counts as a new edge.

## Structure
- Package trade_limiter_pkg holds:
  - channel index width function
  - total-count width constant
  - a channel-state struct (count, win_cnt, halt, throttle)
- Sub-module trade_ch_counter, instantiated NUM_CH times in a generate loop, contains:
  - edge detect
  - limit register
  - count/window counters
  - halt/throttle for one channel
- Top level holds:
  - win_timer
  - total adder/saturation
  - global halt
  - cfg decode and readback mux

## Test plan
Config for all scenarios: NUM_CH=4, CNT_W=8, DEFAULT_LIMIT=5, WINDOW_CYCLES=16, RATE_MAX=3, GLOBAL_MAX=12.
- Ch0 match held high 10 cycles -> one accept_pulse, count0=1, total=1.
- Ch1 gets 5 edges spread over 3 windows -> count1=5; halt_vec[1] rises the cycle after the 5th accept; 6th edge gives no pulse and count1 stays 5.
- Ch2 gets 4 edges within one window -> throttle_vec[2] after the 3rd; 4th dropped; throttle clears at wrap; next edge accepted (count2=4).
- Write limit ch3=2 after count3=3 -> halt_vec[3]=1 one cycle after the write; clear_ch[3] together with an edge -> count3=0, halt=0, no pulse.
- Edges on all 4 channels in the same cycle, repeated across windows -> total steps by 4; global_halt asserts when total reaches 12; clear_all -> total=0, limits unchanged.
- Assert reset mid-window with count0=2 and match0 high -> all outputs 0; after release, the held-high match0 counts as one accept.
